pila_lifo: RTL and testbench
============================

Name: pila_lifo

Overview:
- Hardware LIFO stack at the far end of the control unit's push/pop interface.
- On call-style instructions the control unit asserts push and the block saves the supplied value (the return PC).
- On pop it releases the top entry; the top-of-stack output drives the PC mux whenever s_pila selects the stack.
- Single-cycle CPU, so top-of-stack is readable combinationally; the pointer updates on the clock edge.

Parameters:
- WIDTH, 10, bit width of each entry (PC width).
- DEPTH, 8, number of entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write din onto the stack this cycle.
- pop  in  1  remove the top entry this cycle.
- din  in  WIDTH  value to push (next PC / return address).
- dout  out  WIDTH  current top entry, combinational from stored state; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- overflow  out  1  sticky flag: push attempted while full.
- underflow  out  1  sticky flag: pop attempted while empty.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: count=0, top pointer=0, bottom pointer=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, dout=0.
  - Memory contents are not cleared.
- Reset has priority over push/pop in the same cycle.
- A reset in the middle of any sequence discards all entries.
- All state changes occur on the rising edge; dout/empty/full/count reflect the registered state.
- dout = mem[top-1] (modulo DEPTH) when count>0, else 0.
  - No read latency: a pop in cycle N presents the entry in cycle N; the next entry appears in cycle N+1.
- Per-edge operation, with push/pop sampled together:
  - push only, not full: mem[top] <= din; top++; count++.
  - push only, full: see Optional Feature; overflow <= 1 in all builds.
  - pop only, not empty: top--; count--.
  - pop only, empty: no state change except underflow <= 1.
  - push and pop, not empty: replace top, i.e. mem[top-1] <= din; top and count unchanged; no flags.
  - push and pop, empty: treated as push only; underflow <= 1.
  - neither: hold.
- Pointer arithmetic is modulo DEPTH (natural wrap of a log2(DEPTH)-bit pointer).
- count never exceeds DEPTH and never goes below 0.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: PILA_WRAP_EN.
- Defined (circular mode):
  - A push while full overwrites the oldest entry: mem[top] <= din; top++; bottom++; count stays DEPTH; overflow <= 1.
  - Deep recursion keeps the most recent DEPTH return addresses.
- Not defined (default):
  - A push while full is dropped; mem, top and count are unchanged; overflow <= 1.
  - The bottom pointer is not implemented (constant 0).

Decomposition:
- Shared package/header pila_pkg holds:
  - default PILA_WIDTH=10 and PILA_DEPTH=8;
  - pointer-width constant PILA_PTR_W = $clog2(PILA_DEPTH).
- The control unit and CPU top import the same defaults.
- One sub-module, pila_mem: DEPTH x WIDTH register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), no reset.
- pila_lifo holds the pointers, count, flags and operation decode.

Test Plan (bench uses WIDTH=10, DEPTH=4):
- Reset, then push 0x011, 0x022, 0x033 on successive cycles -> count=3; dout=0x033; empty=0, full=0. Then pop x3 -> dout reads 0x033, 0x022, 0x011 in the pop cycles; count=0; empty=1; dout=0.
- Fill with 0x001..0x004, then push 0x005:
  - Without PILA_WRAP_EN -> count=4; dout=0x004; overflow=1; popping 4 times yields 0x004..0x001.
  - With PILA_WRAP_EN -> dout=0x005; count=4; popping yields 0x005, 0x004, 0x003, 0x002; overflow=1.
- Pop on empty -> underflow=1; count=0; dout=0. Then push 0x3FF -> dout=0x3FF; underflow stays 1 until reset.
- Stack holds 0x100, 0x200; push=pop=1 with din=0x2AA -> count=2; dout=0x2AA; next pop reveals 0x100.
- push=pop=1 on empty with din=0x055 -> count=1; dout=0x055; underflow=1.
- Push 0x0AA twice, then assert reset together with push=1 -> next cycle count=0, empty=1, overflow=0, underflow=0, dout=0.

Source files
------------

// File: rtl/pila_pkg.sv
// Shared defaults and operation decode for the return-address stack.
// Imported by the stack, its interface and the control unit / CPU top.
package pila_pkg;

    localparam int PILA_WIDTH = 10;
    localparam int PILA_DEPTH = 8;
    localparam int PILA_PTR_W = $clog2(PILA_DEPTH);

    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } pila_op_e;

    function automatic pila_op_e pila_decode(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPLACE;
            default: return OP_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/pila_if.sv
// Push/pop bus between the control unit (master) and the LIFO (slave).
// Top-of-stack and status are combinational from the stack's registered state.
interface pila_if
    import pila_pkg::*;
#(
    parameter int WIDTH = PILA_WIDTH,
    parameter int DEPTH = PILA_DEPTH
);
    logic                     push;
    logic                     pop;
    logic [WIDTH-1:0]         din;
    logic [WIDTH-1:0]         dout;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push, pop, din,
        input  dout, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, din,
        output dout, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/pila_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// No reset; contents survive a stack reset and are masked by the count instead.
module pila_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pila_lifo.sv
// Return-address LIFO; PILA_WRAP_EN makes a push while full overwrite the oldest entry.
// Top-of-stack is combinational (zero read latency); pointers/flags update on the rising edge.
module pila_lifo
    import pila_pkg::*;
#(
    parameter int WIDTH = PILA_WIDTH,
    parameter int DEPTH = PILA_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    pila_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]    top, top_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             udf, udf_nxt;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [PW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             is_empty;
    logic             is_full;
    pila_op_e         op;
`ifdef PILA_WRAP_EN
    logic [PW-1:0]    bottom, bottom_nxt;
`endif

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);
    assign raddr    = top - PW'(1);
    assign op       = pila_decode(bus.push, bus.pop);

    always_comb begin
        top_nxt = top;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        udf_nxt = udf;
        we      = 1'b0;
        waddr   = top;
`ifdef PILA_WRAP_EN
        bottom_nxt = bottom;
`endif
        case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    top_nxt = top + PW'(1);
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    ovf_nxt = 1'b1;
`ifdef PILA_WRAP_EN
                    // Circular mode: slot at top is the oldest entry, so both pointers advance.
                    we         = 1'b1;
                    top_nxt    = top + PW'(1);
                    bottom_nxt = bottom + PW'(1);
`endif
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    top_nxt = top - PW'(1);
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    udf_nxt = 1'b1;
                end
            end
            OP_REPLACE: begin
                we = 1'b1;
                if (!is_empty) begin
                    waddr = raddr;
                end else begin
                    // Nothing to pop: behaves as a plain push but the bad pop is still flagged.
                    top_nxt = top + PW'(1);
                    cnt_nxt = cnt + CW'(1);
                    udf_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
`ifdef PILA_WRAP_EN
            bottom <= '0;
`endif
        end else begin
            top <= top_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            udf <= udf_nxt;
`ifdef PILA_WRAP_EN
            bottom <= bottom_nxt;
`endif
        end
    end

    pila_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.din),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.dout      = is_empty ? '0 : rdata;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
endmodule

// File: tb/tb_pila_lifo.sv
// Bench for pila_lifo (WIDTH=10, DEPTH=4): directed vector table plus random traffic vs a queue model.
module tb_pila_lifo;
    localparam int W = 10;
    localparam int D = 4;

    typedef struct {
        logic         rst;
        logic         push;
        logic         pop;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic [2:0]   cnt;
        logic         emp;
        logic         ful;
        logic         ovf;
        logic         udf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    pila_if #(.WIDTH(W), .DEPTH(D)) bus();

    pila_lifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    // Reference model: the stack as a queue, top at the back.
    int unsigned mq[$];
    logic        m_ovf;
    logic        m_udf;

    function automatic vec_t mk(input logic r, input logic p, input logic o, input logic [W-1:0] di,
                                input logic [W-1:0] dd, input logic [2:0] c, input logic e,
                                input logic f, input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.push = p; v.pop = o; v.din = di;
        v.dout = dd; v.cnt = c; v.emp = e; v.ful = f; v.ovf = ov; v.udf = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] dd, input logic [2:0] c,
                             input logic e, input logic f, input logic ov, input logic un);
        check({tag, ".dout"},      32'(bus.dout),      32'(dd));
        check({tag, ".count"},     32'(bus.count),     32'(c));
        check({tag, ".empty"},     32'(bus.empty),     32'(e));
        check({tag, ".full"},      32'(bus.full),      32'(f));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(ov));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(un));
    endtask

    task automatic model_step(input logic r, input logic p, input logic o, input logic [W-1:0] di);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (p && o) begin
            if (mq.size() == 0) begin
                mq.push_back(int'(di));
                m_udf = 1'b1;
            end else begin
                mq[mq.size()-1] = int'(di);
            end
        end else if (p) begin
            if (mq.size() < D) begin
                mq.push_back(int'(di));
            end else begin
                m_ovf = 1'b1;
`ifdef PILA_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(int'(di));
`endif
            end
        end else if (o) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    initial begin
        logic         r, p, o;
        logic [W-1:0] di;
        logic [W-1:0] m_dout;
        int           bias;

        // Each row: inputs applied this cycle, outputs expected in the same cycle (pre-edge state).
        vecs.push_back(mk(0,1,0,10'h011, 10'h000,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,10'h022, 10'h011,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,10'h033, 10'h022,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h033,3,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h022,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h011,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,10'h000, 10'h000,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,10'h001, 10'h000,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,10'h002, 10'h001,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,10'h003, 10'h002,2,0,0,0,0));
        vecs.push_back(mk(0,1,0,10'h004, 10'h003,3,0,0,0,0));
        vecs.push_back(mk(0,1,0,10'h005, 10'h004,4,0,1,0,0));
`ifdef PILA_WRAP_EN
        vecs.push_back(mk(0,0,1,10'h000, 10'h005,4,0,1,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h004,3,0,0,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h003,2,0,0,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h002,1,0,0,1,0));
`else
        vecs.push_back(mk(0,0,1,10'h000, 10'h004,4,0,1,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h003,3,0,0,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h002,2,0,0,1,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h001,1,0,0,1,0));
`endif
        vecs.push_back(mk(0,0,1,10'h000, 10'h000,0,1,0,1,0));
        vecs.push_back(mk(0,1,0,10'h3FF, 10'h000,0,1,0,1,1));
        vecs.push_back(mk(0,0,0,10'h000, 10'h3FF,1,0,0,1,1));
        vecs.push_back(mk(1,0,0,10'h000, 10'h3FF,1,0,0,1,1));
        vecs.push_back(mk(0,1,0,10'h100, 10'h000,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,10'h200, 10'h100,1,0,0,0,0));
        vecs.push_back(mk(0,1,1,10'h2AA, 10'h200,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h2AA,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h000, 10'h100,1,0,0,0,0));
        vecs.push_back(mk(0,1,1,10'h055, 10'h000,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,10'h000, 10'h055,1,0,0,0,1));
        vecs.push_back(mk(0,1,0,10'h0AA, 10'h055,1,0,0,0,1));
        vecs.push_back(mk(0,1,0,10'h0AA, 10'h0AA,2,0,0,0,1));
        vecs.push_back(mk(1,1,0,10'h0AA, 10'h0AA,3,0,0,0,1));
        vecs.push_back(mk(0,0,0,10'h000, 10'h000,0,1,0,0,0));

        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = '0;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            bus.push = vecs[i].push;
            bus.pop  = vecs[i].pop;
            bus.din  = vecs[i].din;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt,
                      vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].udf);
        end

        // Table ends in the post-reset idle state.
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        bias  = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) bias = (bias == 70) ? 30 : 70;
            r  = ($urandom_range(0, 99) == 0);
            p  = ($urandom_range(0, 99) < bias);
            o  = ($urandom_range(0, 99) >= bias);
            if ($urandom_range(0, 7) == 0) begin p = 1'b1; o = 1'b1; end
            di = W'($urandom_range(0, 1023));
            @(negedge clk);
            reset    = r;
            bus.push = p;
            bus.pop  = o;
            bus.din  = di;
            #1;
            m_dout = (mq.size() > 0) ? W'(mq[mq.size()-1]) : '0;
            check_all($sformatf("rnd%0d", i), m_dout, 3'(mq.size()),
                      mq.size() == 0, mq.size() == D, m_ovf, m_udf);
            model_step(r, p, o, di);
        end

        @(negedge clk);
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
